// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the byte-stream register bus bridge.
// States, command layout and bus widths.
package reg_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_HI,
    WR_LO,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    TX_HI,
    TX_LO,
    TX_ACK
  } state_e;

  localparam int CMD_WRITE_BIT = 7;
  localparam int REG_INDEX_W   = 7;
  localparam int REG_DATA_W    = 16;

  localparam logic [7:0] DEFAULT_ACK = 8'h06;

endpackage

// File: rtl/reg_bus_bridge.sv
// Host byte channel to register bus initiator.
// Decodes read/write commands, strobes the bus, returns bytes.
module reg_bus_bridge
  import reg_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [REG_INDEX_W-1:0] register_index,
  output logic                   register_read,
  output logic                   register_write,
  output logic [REG_DATA_W-1:0]  register_write_value,
  input  logic [REG_DATA_W-1:0]  register_read_value,
  output logic                   busy
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                 r_state;
  state_e                 w_next;
  logic [REG_INDEX_W-1:0] r_index;
  logic [REG_DATA_W-1:0]  r_value;
  logic [REG_DATA_W-1:0]  r_hold;
  logic [CW-1:0]          r_cnt;

  logic w_rx_hs;
  logic w_waiting;
  logic w_expired;

  assign w_rx_hs   = rx_valid && rx_ready;
  assign w_waiting = (r_state == WR_HI) || (r_state == WR_LO);
  assign w_expired = (TIMEOUT_CYCLES != 0) &&
                     (r_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An accepted byte wins over a timeout reached in the same cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rx_hs)
          w_next = rx_data[CMD_WRITE_BIT] ? WR_HI : RD_ISSUE;
      end
      WR_HI: begin
        if (w_rx_hs)        w_next = WR_LO;
        else if (w_expired) w_next = IDLE;
      end
      WR_LO: begin
        if (w_rx_hs)        w_next = WR_ISSUE;
        else if (w_expired) w_next = IDLE;
      end
      WR_ISSUE: w_next = TX_ACK;
      TX_ACK:   if (tx_ready) w_next = IDLE;
      RD_ISSUE: w_next = RD_WAIT;
      RD_WAIT:  w_next = TX_HI;
      TX_HI:    if (tx_ready) w_next = TX_LO;
      TX_LO:    if (tx_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= '0;
      r_value <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_rx_hs)
        r_index <= rx_data[REG_INDEX_W-1:0];
      if (r_state == WR_HI && w_rx_hs)
        r_value[15:8] <= rx_data;
      if (r_state == WR_LO && w_rx_hs)
        r_value[7:0] <= rx_data;
      if (r_state == RD_WAIT)
        r_hold <= register_read_value;
      if (w_waiting && !w_rx_hs && !w_expired)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (r_state)
      TX_ACK:  tx_data = ACK_BYTE;
      TX_HI:   tx_data = r_hold[15:8];
      TX_LO:   tx_data = r_hold[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  assign rx_ready = (r_state == IDLE) || w_waiting;
  assign tx_valid = (r_state == TX_ACK) ||
                    (r_state == TX_HI) ||
                    (r_state == TX_LO);

  assign register_read        = (r_state == RD_ISSUE);
  assign register_write       = (r_state == WR_ISSUE);
  assign register_index       = r_index;
  assign register_write_value = r_value;
  assign busy                 = (r_state != IDLE);

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Bench for reg_bus_bridge: directed table, corner sequences,
// and random commands against a memory-array reference model.
module tb_reg_bus_bridge;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        busy;

  always #5 clk = ~clk;

  reg_bus_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE      (8'h06)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_ready            (rx_ready),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_ready            (tx_ready),
    .register_index      (register_index),
    .register_read       (register_read),
    .register_write      (register_write),
    .register_write_value(register_write_value),
    .register_read_value (register_read_value),
    .busy                (busy)
  );

  logic [15:0] dev_mem [128];
  logic [15:0] mdl_mem [128];
  logic [23:0] obs_str [$];
  logic [23:0] exp_str [$];
  logic [7:0]  obs_tx  [$];
  logic [7:0]  exp_tx  [$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rx = 0;
  logic prev_str = 1'b0;
  logic prev_txv = 1'b0;
  logic prev_txr = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  bit   rand_txr = 1'b0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Responder: read data valid only the cycle after the strobe.
  always @(posedge clk) begin
    if (register_write)
      dev_mem[register_index] <= register_write_value;
    register_read_value <= register_read ?
      dev_mem[register_index] : 16'($urandom);
  end

  always @(posedge clk) begin
    #1;
    if (rand_txr) tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_str = 1'b0;
      prev_txv = 1'b0;
    end else begin
      if (register_read || register_write) begin
        chk("strobe_excl", 32'(register_read & register_write), 0);
        chk("strobe_gap", 32'(prev_str), 0);
        chk("strobe_lat", cyc - last_rx, 1);
        obs_str.push_back({register_write, register_index,
          register_write ? register_write_value : 16'h0});
      end
      if (prev_txv && !prev_txr) begin
        chk("tx_hold_valid", 32'(tx_valid), 1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_txd));
      end
      if (tx_valid) chk("rx_ready_in_tx", 32'(rx_ready), 0);
      if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
      if (rx_valid && rx_ready) last_rx = cyc;
      prev_str = register_read | register_write;
      prev_txv = tx_valid;
      prev_txr = tx_ready;
      prev_txd = tx_data;
    end
  end

  task automatic clear_obs();
    obs_str.delete();
    obs_tx.delete();
    exp_str.delete();
    exp_tx.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    @(negedge clk);
    while (!rx_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) chk("rx_hs_timeout", 32'(rx_ready), 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_cmd(input bit wr, input logic [6:0] idx,
                         input logic [15:0] val, input int gap);
    send_byte({wr, idx}, gap);
    if (wr) begin
      send_byte(val[15:8], gap);
      send_byte(val[7:0], gap);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_txv();
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("txv_seen", 32'(tx_valid), 1);
  endtask

  typedef struct {
    bit          wr;
    logic [6:0]  idx;
    logic [15:0] val;
    int          ntx;
    logic [7:0]  t0;
    logic [7:0]  t1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] v;
    bit          wr;
    logic [6:0]  idx;
    logic [15:0] val;
    int          gap;
    int          n;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      dev_mem[i] = v;
      mdl_mem[i] = v;
    end
    dev_mem[6]     = 16'h000A; mdl_mem[6]     = 16'h000A;
    dev_mem[7'h10] = 16'hBEEF; mdl_mem[7'h10] = 16'hBEEF;
    dev_mem[3]     = 16'hC0DE; mdl_mem[3]     = 16'hC0DE;

    tbl[0] = '{1'b1, 7'h01, 16'h1234, 1, 8'h06, 8'h00};
    tbl[1] = '{1'b0, 7'h06, 16'h0000, 2, 8'h00, 8'h0A};
    tbl[2] = '{1'b0, 7'h01, 16'h0000, 2, 8'h12, 8'h34};
    tbl[3] = '{1'b1, 7'h00, 16'h0000, 1, 8'h06, 8'h00};
    tbl[4] = '{1'b0, 7'h00, 16'h0000, 2, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 7'h7F, 16'hFFFF, 1, 8'h06, 8'h00};
    tbl[6] = '{1'b0, 7'h7F, 16'h0000, 2, 8'hFF, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rd", 32'(register_read), 0);
    chk("rst_wr", 32'(register_write), 0);
    chk("rst_index", 32'(register_index), 0);
    chk("rst_wval", 32'(register_write_value), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) begin
      clear_obs();
      run_cmd(tbl[t].wr, tbl[t].idx, tbl[t].val, 0);
      wait_idle();
      chk("tbl_nstr", obs_str.size(), 1);
      if (obs_str.size() > 0)
        chk("tbl_str", 32'(obs_str[0]), 32'({tbl[t].wr, tbl[t].idx,
          tbl[t].wr ? tbl[t].val : 16'h0}));
      chk("tbl_ntx", obs_tx.size(), tbl[t].ntx);
      if (obs_tx.size() > 0) chk("tbl_tx0", 32'(obs_tx[0]), 32'(tbl[t].t0));
      if (obs_tx.size() > 1) chk("tbl_tx1", 32'(obs_tx[1]), 32'(tbl[t].t1));
      if (tbl[t].wr) mdl_mem[tbl[t].idx] = tbl[t].val;
    end

    // Back-pressure on the first read byte.
    clear_obs();
    tx_ready = 1'b0;
    run_cmd(1'b0, 7'h10, 16'h0, 0);
    wait_txv();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(tx_valid), 1);
      chk("bp_data", 32'(tx_data), 32'h BE);
      chk("bp_rx_ready", 32'(rx_ready), 0);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle();
    chk("bp_ntx", obs_tx.size(), 2);
    if (obs_tx.size() > 1) begin
      chk("bp_tx0", 32'(obs_tx[0]), 32'hBE);
      chk("bp_tx1", 32'(obs_tx[1]), 32'hEF);
    end

    // Abandoned write times out silently.
    clear_obs();
    send_byte(8'h82, 0);
    send_byte(8'h55, 0);
    repeat (5) @(negedge clk);
    chk("to_still_busy", 32'(busy), 1);
    repeat (7) @(negedge clk);
    chk("to_idle", 32'(busy), 0);
    chk("to_rx_ready", 32'(rx_ready), 1);
    chk("to_nstr", obs_str.size(), 0);
    chk("to_ntx", obs_tx.size(), 0);
    @(posedge clk);
    #1;
    run_cmd(1'b0, 7'h03, 16'h0, 0);
    wait_idle();
    chk("to_rd_nstr", obs_str.size(), 1);
    if (obs_str.size() > 0)
      chk("to_rd_str", 32'(obs_str[0]), 32'({1'b0, 7'h03, 16'h0}));
    chk("to_rd_ntx", obs_tx.size(), 2);
    if (obs_tx.size() > 1) begin
      chk("to_rd_tx0", 32'(obs_tx[0]), 32'hC0);
      chk("to_rd_tx1", 32'(obs_tx[1]), 32'hDE);
    end

    // Reset while a read response is pending.
    clear_obs();
    tx_ready = 1'b0;
    run_cmd(1'b0, 7'h06, 16'h0, 0);
    wait_txv();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_tx_valid", 32'(tx_valid), 0);
    chk("mr_tx_data", 32'(tx_data), 0);
    chk("mr_rx_ready", 32'(rx_ready), 1);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rd", 32'(register_read), 0);
    chk("mr_wr", 32'(register_write), 0);
    clear_obs();
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mr_ntx", obs_tx.size(), 0);
    chk("mr_nstr", obs_str.size(), 0);
    @(posedge clk);
    #1;

    // Write immediately followed by a read of the same register.
    clear_obs();
    run_cmd(1'b1, 7'h05, 16'h007F, 0);
    run_cmd(1'b0, 7'h05, 16'h0, 0);
    wait_idle();
    mdl_mem[5] = 16'h007F;
    chk("b2b_nstr", obs_str.size(), 2);
    if (obs_str.size() > 1) begin
      chk("b2b_str0", 32'(obs_str[0]), 32'({1'b1, 7'h05, 16'h007F}));
      chk("b2b_str1", 32'(obs_str[1]), 32'({1'b0, 7'h05, 16'h0}));
    end
    chk("b2b_ntx", obs_tx.size(), 3);
    if (obs_tx.size() > 2) begin
      chk("b2b_tx0", 32'(obs_tx[0]), 32'h06);
      chk("b2b_tx1", 32'(obs_tx[1]), 32'h00);
      chk("b2b_tx2", 32'(obs_tx[2]), 32'h7F);
    end

    // Random traffic with random tx back-pressure.
    clear_obs();
    rand_txr = 1'b1;
    for (int r = 0; r < 40; r++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = 7'($urandom);
      val = 16'($urandom);
      gap = $urandom_range(0, 3);
      if (wr) begin
        exp_str.push_back({1'b1, idx, val});
        exp_tx.push_back(8'h06);
        mdl_mem[idx] = val;
      end else begin
        v = mdl_mem[idx];
        exp_str.push_back({1'b0, idx, 16'h0});
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
      end
      run_cmd(wr, idx, val, gap);
    end
    wait_idle();
    rand_txr = 1'b0;
    tx_ready = 1'b1;
    chk("rnd_nstr", obs_str.size(), exp_str.size());
    n = (obs_str.size() < exp_str.size()) ? obs_str.size()
                                          : exp_str.size();
    for (int i = 0; i < n; i++)
      chk("rnd_str", 32'(obs_str[i]), 32'(exp_str[i]));
    chk("rnd_ntx", obs_tx.size(), exp_tx.size());
    n = (obs_tx.size() < exp_tx.size()) ? obs_tx.size()
                                        : exp_tx.size();
    for (int i = 0; i < n; i++)
      chk("rnd_tx", 32'(obs_tx[i]), 32'(exp_tx[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
